mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-master arbiter that shares the single data memory port between the instruction fetch unit (IFU) and the load/store unit (LSU) of the NPC core. Each master uses a valid/ready request channel and a valid/ready response channel. The arbiter owns one outstanding transaction at a time and forwards it to the memory-side port, which carries the DPI-backed read/write model. A watchdog returns an error response if memory never answers.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; wmask width is DATA_W/8
- TIMEOUT, 255, WAIT-state cycles before an error response; must be ≥1
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- ifu_req_valid / ifu_req_ready  in / out  1  IFU request handshake
- ifu_req_addr  in  ADDR_W  fetch address; IFU requests are always reads
- ifu_resp_valid / ifu_resp_ready  out / in  1  IFU response handshake
- ifu_resp_rdata  out  DATA_W  read data
- ifu_resp_err  out  1  error flag, set on timeout
- lsu_req_valid / lsu_req_ready  in / out  1  LSU request handshake
- lsu_req_addr  in  ADDR_W  request address
- lsu_req_wen  in  1  1 = write, 0 = read
- lsu_req_wdata  in  DATA_W  write data
- lsu_req_wmask  in  DATA_W/8  byte enables
- lsu_resp_valid / lsu_resp_ready / lsu_resp_rdata / lsu_resp_err  as for IFU
- mem_req_valid / mem_req_ready  out / in  1  memory request handshake
- mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask  out  as LSU  latched request fields
- mem_resp_valid  in  1  memory response strobe; there is no backpressure on it
- mem_resp_rdata  in  DATA_W  response data
- busy  out  1  state != IDLE

## Operation
- **States:** IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - The grant is computed combinationally from the two req_valid inputs.
  - Only the granted master's req_ready is 1; the other master's req_ready is 0.
  - On handshake, the arbiter latches addr, wen, wdata, wmask and owner, then goes to ISSUE.
  - Latched fields for an IFU request: wen = 0, wmask = 0, wdata = 0.
- **ISSUE:**
  - mem_req_valid = 1, driven from the latched fields, which stay stable.
  - When mem_req_ready is 1, go to WAIT and clear the watchdog counter.
- **WAIT:**
  - The counter increments every cycle.
  - When mem_resp_valid is 1, latch rdata, set err = 0 and go to RESP.
  - If instead the counter reaches TIMEOUT-1 without a response, set rdata = 0, err = 1 and go to RESP.
- **RESP:**
  - The owner's resp_valid = 1, with rdata and err held stable.
  - When the owner's resp_ready is 1, go to IDLE.
  - The other master's resp_valid stays 0.
- **Write responses:** writes also produce a response, with rdata forwarded as received.
- **Ignored memory responses:** mem_resp_valid outside WAIT is ignored. This covers late responses after a timeout and responses in flight across a reset.
- **Both masters valid in IDLE:** the outcome is set by the arbitration policy described under Configuration.
- **Reset:** takes effect mid-transaction, from any state.
  - State goes to IDLE; counter, latched fields and last_grant are cleared.
  - Every valid and ready output is 0 in the cycle after reset is sampled.
  - Reset values of all outputs: ifu_req_ready and lsu_req_ready 0 while reset is held; all response and mem_req outputs 0; busy 0.

## Timing
- Request acceptance (IDLE→ISSUE) takes 1 cycle; mem_req_valid rises the cycle after the master's handshake.
- Minimum transaction, with memory ready and responding the cycle after acceptance: 4 cycles from master request handshake to response handshake.
  - Cycle 0: request handshake (IDLE).
  - Cycle 1: ISSUE.
  - Cycle 2: WAIT with response.
  - Cycle 3: RESP with resp_ready.
- There is one mandatory IDLE cycle between transactions; no request is accepted in the RESP exit cycle.
- Timeout response: resp_valid is asserted TIMEOUT+2 cycles after acceptance.
- The counter is $clog2(TIMEOUT+1) bits wide and saturates; it never wraps.

## Configuration
- **ARB_RR_EN defined:** round-robin.
  - On a tie, grant the master not recorded in last_grant.
  - last_grant updates on every IDLE handshake.
  - last_grant resets to IFU, so the first tie goes to the LSU.
- **ARB_RR_EN undefined:** fixed priority; the LSU always wins a tie and the last_grant register is absent.

## Structure
- **Package mem_arb_pkg:**
  - state enum (IDLE/ISSUE/WAIT/RESP)
  - owner typedef (OWN_IFU = 0, OWN_LSU = 1)
  - default ADDR_W/DATA_W/TIMEOUT localparams
- **Sub-module arb_grant:**
  - Inputs: two valids and, under ARB_RR_EN, last_grant.
  - Outputs: the grant one-hot and the owner id.
  - Purely combinational.
- The FSM, latches and watchdog live in mem_arbiter.

## Test plan
- IFU read 0x8000_0000 alone, memory ready immediately, responds next cycle with 0xDEAD_BEEF → ifu_resp_rdata = 0xDEAD_BEEF, err = 0, 4-cycle transaction, lsu_resp_valid stays 0.
- LSU write addr 0x8000_0100, wdata 0x1234_5678, wmask 0xF, mem_req_ready held 0 for 3 cycles → mem_req fields stable throughout ISSUE, response delivered to LSU only.
- Both valid in 4 consecutive IDLE windows:
  - With ARB_RR_EN: grant order LSU, IFU, LSU, IFU.
  - Without: LSU four times, and IFU never gets req_ready.
- TIMEOUT = 8, memory never responds → resp_valid at cycle 10 after acceptance with err = 1, rdata = 0. A late mem_resp_valid in the following IDLE produces no response.
- resp_ready held 0 for 5 cycles in RESP → resp_valid, rdata and err held, busy = 1, other master's req_ready = 0.
- Reset asserted during WAIT with mem_resp_valid pulsing in the same cycle → next cycle state is IDLE, all valids 0 and busy 0, and no response is emitted.

Source files
------------

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package   : mem_arb_pkg                                                |
// | Purpose   : Shared types and default sizes for the IFU/LSU memory      |
// |             arbiter (FSM state encoding, owner id, default widths).    |
// | Revision  : 1.0  initial release                                       |
// +------------------------------------------------------------------------+
package mem_arb_pkg;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 255;

    // Arbiter transaction phases
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Which master owns the current transaction
    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

endpackage
`default_nettype wire

// File: rtl/arb_grant.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module    : arb_grant                                                  |
// | Purpose   : Combinational grant selection between IFU and LSU.         |
// |             ARB_RR_EN defined   : round-robin on a tie, using the      |
// |                                   previously granted owner.            |
// |             ARB_RR_EN undefined : fixed priority, LSU wins a tie.      |
// | Revision  : 1.0  initial release                                       |
// +------------------------------------------------------------------------+
module arb_grant
    import mem_arb_pkg::*;
(
    input  logic       ifu_valid,
    input  logic       lsu_valid,
`ifdef ARB_RR_EN
    input  owner_t     last_grant,
`endif
    output logic [1:0] grant,      // bit 0 = IFU, bit 1 = LSU
    output owner_t     owner
);

    // Pick the winner; the grant vector is empty when nobody requests
    always_comb begin
        grant = 2'b00;
        owner = OWN_IFU;
        if (ifu_valid && lsu_valid) begin
`ifdef ARB_RR_EN
            owner = (last_grant == OWN_IFU) ? OWN_LSU : OWN_IFU;
`else
            owner = OWN_LSU;
`endif
        end else if (lsu_valid) begin
            owner = OWN_LSU;
        end else begin
            owner = OWN_IFU;
        end
        if (ifu_valid || lsu_valid) begin
            grant = (owner == OWN_LSU) ? 2'b10 : 2'b01;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module    : mem_arbiter                                                |
// | Purpose   : Shares one memory port between the IFU and the LSU. One    |
// |             transaction in flight at a time; a watchdog turns a        |
// |             missing memory response into an error response.            |
// | Config    : define ARB_RR_EN for round-robin tie breaking, otherwise   |
// |             the LSU has fixed priority.                                |
// | Revision  : 1.0  initial release                                       |
// +------------------------------------------------------------------------+
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                clk,
    input  logic                reset,
    // IFU
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_req_addr,
    output logic                ifu_resp_valid,
    input  logic                ifu_resp_ready,
    output logic [DATA_W-1:0]   ifu_resp_rdata,
    output logic                ifu_resp_err,
    // LSU
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_req_addr,
    input  logic                lsu_req_wen,
    input  logic [DATA_W-1:0]   lsu_req_wdata,
    input  logic [DATA_W/8-1:0] lsu_req_wmask,
    output logic                lsu_resp_valid,
    input  logic                lsu_resp_ready,
    output logic [DATA_W-1:0]   lsu_resp_rdata,
    output logic                lsu_resp_err,
    // Memory side
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic                mem_req_wen,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_resp_rdata,
    output logic                busy
);

    // Counter just wide enough to hold TIMEOUT; it saturates instead of wrapping
    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t              state;
    state_t              next_state;
    owner_t              owner;
    owner_t              grant_owner;
    logic [1:0]          grant;
    logic [ADDR_W-1:0]   addr;
    logic                wen;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wmask;
    logic [DATA_W-1:0]   rdata;
    logic                err;
    logic [CNT_W-1:0]    cnt;
    logic                accept;
    logic                issue_go;
    logic                resp_hit;
    logic                timeout_hit;
`ifdef ARB_RR_EN
    owner_t              last_grant;
`endif

    arb_grant u_arb_grant (
        .ifu_valid  (ifu_req_valid),
        .lsu_valid  (lsu_req_valid),
`ifdef ARB_RR_EN
        .last_grant (last_grant),
`endif
        .grant      (grant),
        .owner      (grant_owner)
    );

    // Next-state logic and handshake outputs
    always_comb begin
        next_state     = state;
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        mem_req_valid  = 1'b0;
        ifu_resp_valid = 1'b0;
        lsu_resp_valid = 1'b0;
        accept         = 1'b0;
        issue_go       = 1'b0;
        resp_hit       = 1'b0;
        timeout_hit    = 1'b0;
        case (state)
            ST_IDLE: begin
                // Readies stay low while reset is held so nothing is half-accepted
                if (!reset) begin
                    ifu_req_ready = grant[0];
                    lsu_req_ready = grant[1];
                    accept        = |grant;
                end
                if (accept) begin
                    next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    issue_go   = 1'b1;
                    next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_resp_valid) begin
                    resp_hit   = 1'b1;
                    next_state = ST_RESP;
                end else if (cnt == CNT_LAST) begin
                    timeout_hit = 1'b1;
                    next_state  = ST_RESP;
                end
            end
            ST_RESP: begin
                ifu_resp_valid = (owner == OWN_IFU);
                lsu_resp_valid = (owner == OWN_LSU);
                if ((owner == OWN_IFU && ifu_resp_ready) ||
                    (owner == OWN_LSU && lsu_resp_ready)) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Request latch, watchdog counter and response capture
    always_ff @(posedge clk) begin
        if (reset) begin
            owner <= OWN_IFU;
            addr  <= '0;
            wen   <= 1'b0;
            wdata <= '0;
            wmask <= '0;
            rdata <= '0;
            err   <= 1'b0;
            cnt   <= '0;
        end else begin
            if (accept) begin
                owner <= grant_owner;
                if (grant_owner == OWN_LSU) begin
                    addr  <= lsu_req_addr;
                    wen   <= lsu_req_wen;
                    wdata <= lsu_req_wdata;
                    wmask <= lsu_req_wmask;
                end else begin
                    // Fetches are always plain reads
                    addr  <= ifu_req_addr;
                    wen   <= 1'b0;
                    wdata <= '0;
                    wmask <= '0;
                end
            end
            if (issue_go) begin
                cnt <= '0;
            end else if (state == ST_WAIT) begin
                cnt <= (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
            end
            if (resp_hit) begin
                rdata <= mem_resp_rdata;
                err   <= 1'b0;
            end else if (timeout_hit) begin
                rdata <= '0;
                err   <= 1'b1;
            end
        end
    end

`ifdef ARB_RR_EN
    // Remember who won the last accepted request for tie breaking
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= OWN_IFU;
        end else if (accept) begin
            last_grant <= grant_owner;
        end
    end
`endif

    assign mem_req_addr   = addr;
    assign mem_req_wen    = wen;
    assign mem_req_wdata  = wdata;
    assign mem_req_wmask  = wmask;
    assign ifu_resp_rdata = ifu_resp_valid ? rdata : '0;
    assign ifu_resp_err   = ifu_resp_valid & err;
    assign lsu_resp_rdata = lsu_resp_valid ? rdata : '0;
    assign lsu_resp_err   = lsu_resp_valid & err;
    assign busy           = (state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module    : tb_mem_arbiter                                             |
// | Purpose   : Self-checking bench for mem_arbiter with a response        |
// |             scoreboard. Honours ARB_RR_EN for the tie-break order.     |
// | Revision  : 1.0  initial release                                       |
// +------------------------------------------------------------------------+
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    typedef struct packed {
        logic          own;    // 0 = IFU, 1 = LSU
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready, ifu_resp_err;
    logic [AW-1:0] ifu_req_addr;
    logic [DW-1:0] ifu_resp_rdata;
    logic          lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_resp_valid, lsu_resp_ready, lsu_resp_err;
    logic [AW-1:0] lsu_req_addr;
    logic [DW-1:0] lsu_req_wdata, lsu_resp_rdata;
    logic [DW/8-1:0] lsu_req_wmask, mem_req_wmask;
    logic          mem_req_valid, mem_req_ready, mem_req_wen, mem_resp_valid, busy;
    logic [AW-1:0] mem_req_addr;
    logic [DW-1:0] mem_req_wdata, mem_resp_rdata;

    int   checks;
    int   errors;
    exp_t sb[$];

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
        .ifu_resp_rdata(ifu_resp_rdata), .ifu_resp_err(ifu_resp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
        .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
        .lsu_resp_rdata(lsu_resp_rdata), .lsu_resp_err(lsu_resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Drive point: just after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sample point: the falling edge
    task automatic settle();
        #4;
    endtask

    // Waits (from a drive point) for any resp_valid; ends at a sample point; n = -1 if none
    task automatic wait_resp(input int limit, output int n);
        n = -1;
        for (int i = 0; i < limit; i++) begin
            settle();
            if (ifu_resp_valid || lsu_resp_valid) begin
                n = i;
                return;
            end
            tick();
        end
        settle();
    endtask

    task automatic test_reset();
        reset = 1'b1; ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
        tick(); tick(); settle();
        checks++; if (ifu_req_ready !== 1'b0) begin errors++; $display("FAIL rst_ifu_ready: got %b want 0", ifu_req_ready); end
        checks++; if (lsu_req_ready !== 1'b0) begin errors++; $display("FAIL rst_lsu_ready: got %b want 0", lsu_req_ready); end
        checks++; if ({mem_req_valid, ifu_resp_valid, lsu_resp_valid, busy} !== 4'b0) begin errors++; $display("FAIL rst_valids: got %b want 0000", {mem_req_valid, ifu_resp_valid, lsu_resp_valid, busy}); end
        checks++; if ({mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask} !== '0) begin errors++; $display("FAIL rst_mem_fields: got %h want 0", {mem_req_addr, mem_req_wdata}); end
        tick(); reset = 1'b0; ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        settle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_release_busy: got %b want 0", busy); end
    endtask

    task automatic test_ifu_read();
        exp_t e; int n;
        tick();
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0000;
        mem_req_ready = 1'b1; ifu_resp_ready = 1'b1; lsu_resp_ready = 1'b1;
        settle();
        checks++; if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin errors++; $display("FAIL ifu_grant: got %b want 10", {ifu_req_ready, lsu_req_ready}); end
        tick(); ifu_req_valid = 1'b0; ifu_req_addr = 32'h0;
        settle();
        checks++; if (mem_req_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL ifu_issue: got valid=%b busy=%b want 1 1", mem_req_valid, busy); end
        checks++; if ({mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask} !== {32'h8000_0000, 1'b0, 32'h0, 4'h0}) begin errors++; $display("FAIL ifu_fields: got %h %b %h %h want 80000000 0 0 0", mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask); end
        tick(); mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_rdata = 32'hDEAD_BEEF;
        sb.push_back('{1'b0, 32'hDEAD_BEEF, 1'b0});
        settle();
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL ifu_wait_valid: got %b want 0", mem_req_valid); end
        tick(); mem_resp_valid = 1'b0; ifu_req_valid = 1'b1;
        wait_resp(8, n);
        e = sb.pop_front();
        checks++; if (n !== 0) begin errors++; $display("FAIL ifu_latency: got resp at cycle %0d want 3", n + 3); end
        checks++; if ({ifu_resp_valid, lsu_resp_valid} !== {~e.own, e.own}) begin errors++; $display("FAIL ifu_resp_owner: got %b want %b", {ifu_resp_valid, lsu_resp_valid}, {~e.own, e.own}); end
        checks++; if (ifu_resp_rdata !== e.rdata || ifu_resp_err !== e.err) begin errors++; $display("FAIL ifu_resp_data: got %h/%b want %h/%b", ifu_resp_rdata, ifu_resp_err, e.rdata, e.err); end
        checks++; if (ifu_req_ready !== 1'b0) begin errors++; $display("FAIL ifu_resp_exit_ready: got %b want 0", ifu_req_ready); end
        tick(); ifu_req_valid = 1'b0;
        settle();
        checks++; if (busy !== 1'b0 || ifu_resp_valid !== 1'b0) begin errors++; $display("FAIL ifu_done: got busy=%b valid=%b want 0 0", busy, ifu_resp_valid); end
    endtask

    task automatic test_lsu_write();
        exp_t e; int n;
        tick();
        lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_0100; lsu_req_wen = 1'b1;
        lsu_req_wdata = 32'h1234_5678; lsu_req_wmask = 4'hF; mem_req_ready = 1'b0;
        settle();
        checks++; if ({ifu_req_ready, lsu_req_ready} !== 2'b01) begin errors++; $display("FAIL lsu_grant: got %b want 01", {ifu_req_ready, lsu_req_ready}); end
        tick(); lsu_req_valid = 1'b0; lsu_req_addr = 32'hFFFF_FFFF; lsu_req_wdata = 32'h0; lsu_req_wmask = 4'h0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick();
            if (k == 3) mem_req_ready = 1'b1;
            settle();
            checks++; if ({mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask} !== {1'b1, 32'h8000_0100, 1'b1, 32'h1234_5678, 4'hF}) begin errors++; $display("FAIL lsu_issue_stable[%0d]: got %b %h %b %h %h want 1 80000100 1 12345678 f", k, mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask); end
        end
        tick(); mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_rdata = 32'hA5A5_0001;
        sb.push_back('{1'b1, 32'hA5A5_0001, 1'b0});
        tick(); mem_resp_valid = 1'b0;
        wait_resp(8, n);
        e = sb.pop_front();
        checks++; if ({ifu_resp_valid, lsu_resp_valid} !== {~e.own, e.own}) begin errors++; $display("FAIL lsu_resp_owner: got %b want %b", {ifu_resp_valid, lsu_resp_valid}, {~e.own, e.own}); end
        checks++; if (lsu_resp_rdata !== e.rdata || lsu_resp_err !== e.err) begin errors++; $display("FAIL lsu_resp_data: got %h/%b want %h/%b", lsu_resp_rdata, lsu_resp_err, e.rdata, e.err); end
        tick(); lsu_req_wen = 1'b0;
        settle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lsu_done: got busy=%b want 0", busy); end
    endtask

    task automatic test_arbitration();
        exp_t e; int n; bit lsu_win; logic [DW-1:0] got;
        tick(); reset = 1'b1;
        tick(); reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
`ifdef ARB_RR_EN
            lsu_win = (i % 2 == 0);
`else
            lsu_win = 1'b1;
`endif
            ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
            ifu_req_addr = 32'h1000 + i; lsu_req_addr = 32'h2000 + i;
            settle();
            checks++; if ({ifu_req_ready, lsu_req_ready} !== {~lsu_win, lsu_win}) begin errors++; $display("FAIL arb_ready[%0d]: got %b want %b", i, {ifu_req_ready, lsu_req_ready}, {~lsu_win, lsu_win}); end
            tick(); ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
            settle();
            checks++; if (mem_req_addr !== (lsu_win ? 32'h2000 + i : 32'h1000 + i)) begin errors++; $display("FAIL arb_addr[%0d]: got %h want %h", i, mem_req_addr, lsu_win ? 32'h2000 + i : 32'h1000 + i); end
            tick(); mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_rdata = 32'h100 + i;
            sb.push_back('{lsu_win, 32'h100 + i, 1'b0});
            tick(); mem_resp_valid = 1'b0;
            wait_resp(4, n);
            e = sb.pop_front();
            got = e.own ? lsu_resp_rdata : ifu_resp_rdata;
            checks++; if ({ifu_resp_valid, lsu_resp_valid} !== {~e.own, e.own} || got !== e.rdata) begin errors++; $display("FAIL arb_resp[%0d]: got %b %h want %b %h", i, {ifu_resp_valid, lsu_resp_valid}, got, {~e.own, e.own}, e.rdata); end
            tick(); tick();
        end
    endtask

    task automatic test_timeout();
        exp_t e; int n;
        tick();
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0004; mem_req_ready = 1'b1; ifu_resp_ready = 1'b1;
        settle();
        tick(); ifu_req_valid = 1'b0;
        sb.push_back('{1'b0, 32'h0, 1'b1});
        wait_resp(20, n);
        e = sb.pop_front();
        checks++; if (n + 1 !== TO + 2) begin errors++; $display("FAIL to_latency: got cycle %0d want %0d", n + 1, TO + 2); end
        checks++; if (ifu_resp_valid !== 1'b1 || ifu_resp_rdata !== e.rdata || ifu_resp_err !== e.err) begin errors++; $display("FAIL to_resp: got %b %h %b want 1 %h %b", ifu_resp_valid, ifu_resp_rdata, ifu_resp_err, e.rdata, e.err); end
        tick(); mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_rdata = 32'hBAD0_BAD0;
        settle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_idle_busy: got %b want 0", busy); end
        tick(); mem_resp_valid = 1'b0;
        wait_resp(4, n);
        checks++; if (n !== -1 || busy !== 1'b0) begin errors++; $display("FAIL to_late_ignored: got resp at %0d busy=%b want none 0", n, busy); end
    endtask

    task automatic test_resp_hold();
        exp_t e; int n;
        tick();
        lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_0200; lsu_req_wen = 1'b0; lsu_req_wmask = 4'h0;
        mem_req_ready = 1'b1; lsu_resp_ready = 1'b0;
        settle();
        tick(); lsu_req_valid = 1'b0;
        tick(); mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_rdata = 32'hCAFE_F00D;
        sb.push_back('{1'b1, 32'hCAFE_F00D, 1'b0});
        tick(); mem_resp_valid = 1'b0; ifu_req_valid = 1'b1;
        wait_resp(4, n);
        e = sb.pop_front();
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin tick(); settle(); end
            checks++; if ({lsu_resp_valid, ifu_resp_valid, busy, ifu_req_ready} !== 4'b1010 || lsu_resp_rdata !== e.rdata || lsu_resp_err !== e.err) begin errors++; $display("FAIL hold[%0d]: got v=%b iv=%b busy=%b ir=%b %h %b want 1 0 1 0 %h %b", k, lsu_resp_valid, ifu_resp_valid, busy, ifu_req_ready, lsu_resp_rdata, lsu_resp_err, e.rdata, e.err); end
        end
        tick(); lsu_resp_ready = 1'b1;
        settle();
        checks++; if (lsu_resp_valid !== 1'b1 || ifu_req_ready !== 1'b0) begin errors++; $display("FAIL hold_exit: got v=%b ir=%b want 1 0", lsu_resp_valid, ifu_req_ready); end
        tick(); ifu_req_valid = 1'b0;
        settle();
        checks++; if (busy !== 1'b0 || lsu_resp_valid !== 1'b0) begin errors++; $display("FAIL hold_done: got busy=%b v=%b want 0 0", busy, lsu_resp_valid); end
    endtask

    task automatic test_reset_mid();
        int n;
        tick();
        lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_0300; mem_req_ready = 1'b1; lsu_resp_ready = 1'b1;
        settle();
        tick(); lsu_req_valid = 1'b0;
        tick(); mem_req_ready = 1'b0; reset = 1'b1; mem_resp_valid = 1'b1; mem_resp_rdata = 32'h1111_2222;
        settle();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_in_wait: got busy=%b want 1", busy); end
        tick(); reset = 1'b0; mem_resp_valid = 1'b0;
        settle();
        checks++; if ({busy, mem_req_valid, ifu_resp_valid, lsu_resp_valid, ifu_req_ready, lsu_req_ready} !== 6'b0) begin errors++; $display("FAIL rmid_outputs: got %b want 000000", {busy, mem_req_valid, ifu_resp_valid, lsu_resp_valid, ifu_req_ready, lsu_req_ready}); end
        checks++; if (mem_req_addr !== 32'h0) begin errors++; $display("FAIL rmid_fields: got %h want 0", mem_req_addr); end
        tick();
        wait_resp(5, n);
        checks++; if (n !== -1) begin errors++; $display("FAIL rmid_no_resp: got resp at %0d want none", n); end
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b1;
        ifu_req_valid = 1'b0; ifu_req_addr = '0; ifu_resp_ready = 1'b0;
        lsu_req_valid = 1'b0; lsu_req_addr = '0; lsu_req_wen = 1'b0; lsu_req_wdata = '0; lsu_req_wmask = '0;
        lsu_resp_ready = 1'b0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
        test_reset();
        test_ifu_read();
        test_lsu_write();
        test_arbitration();
        test_timeout();
        test_resp_hold();
        test_reset_mid();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire
